psram_slave: RTL and testbench



---
 rtl/psram_slave.sv | 209 ++++++++++++++++++++
 tb/tb_psram_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_slave.sv
// PSRAM responder for the psram_ctrl link: decodes SPI/QPI command, address and wait phases, serves a byte memory.
// PSRAM_SLAVE_PAGE_WRAP_EN keeps address increments inside a 1024-byte page (needs AW >= 10). IO output is dout because 'do' is reserved.
`timescale 1ns/1ps
module psram_slave #(
  parameter int AW           = 10,
  parameter int FAST_RD_WAIT = 8,
  parameter int QUAD_RD_WAIT = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ncs,
  input  logic       sck,
  input  logic [3:0] di,
  output logic [3:0] dout,
  output logic [3:0] do_en,
  output logic       qpi_mode,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RD_DATA, WR_DATA, IGNORE} state_t;

  typedef struct packed {
    logic       ok;
    logic       rd;
    logic       quad;
    logic [7:0] wait_len;
    logic       enter;
    logic       leave;
  } cmd_t;

  function automatic cmd_t decode(input logic [7:0] c, input logic qpi);
    cmd_t d;
    d = '0;
    if (!qpi) begin
      unique case (c)
        8'h03: begin d.ok = 1'b1; d.rd = 1'b1; end
        8'h0B: begin d.ok = 1'b1; d.rd = 1'b1; d.wait_len = 8'(FAST_RD_WAIT); end
        8'h02: d.ok = 1'b1;
        8'hEB: begin d.ok = 1'b1; d.rd = 1'b1; d.quad = 1'b1; d.wait_len = 8'(QUAD_RD_WAIT); end
        8'h38: begin d.ok = 1'b1; d.quad = 1'b1; end
        8'h35: begin d.ok = 1'b1; d.enter = 1'b1; end
        8'hF5: begin d.ok = 1'b1; d.leave = 1'b1; end
        default: ;
      endcase
    end else begin
      unique case (c)
        8'h03, 8'h0B, 8'hEB: begin
          d.ok = 1'b1; d.rd = 1'b1; d.quad = 1'b1; d.wait_len = 8'(QUAD_RD_WAIT);
        end
        8'h02, 8'h38: begin d.ok = 1'b1; d.quad = 1'b1; end
        8'hF5:        begin d.ok = 1'b1; d.leave = 1'b1; end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    logic [AW-1:0] n;
`ifdef PSRAM_SLAVE_PAGE_WRAP_EN
    n      = a;
    n[9:0] = a[9:0] + 10'd1;
`else
    n = a + AW'(1);
`endif
    return n;
  endfunction

  state_t        state, state_nxt;
  logic          ncs_q, sck_q, sck_q2;
  logic [3:0]    di_q;
  logic          rise, fall, x4;
  logic [23:0]   sh, sh_in;
  logic [7:0]    cnt, unit_last;
  logic [AW-1:0] addr, addr_nxt;
  logic [7:0]    rd_byte;
  logic          rd_q, quad_q;
  logic [7:0]    wait_q;
  cmd_t          dec;
  logic          cmd_done, addr_done, wait_done, byte_done;
  logic [7:0]    mem [0:(1<<AW)-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ncs_q  <= 1'b1;
      sck_q  <= 1'b0;
      sck_q2 <= 1'b0;
      di_q   <= '0;
    end else begin
      ncs_q  <= ncs;
      sck_q  <= sck;
      sck_q2 <= sck_q;
      di_q   <= di;
    end
  end

  // Edges only count while selected, so a deselect freezes the whole engine.
  assign rise      = sck_q & ~sck_q2 & ~ncs_q;
  assign fall      = ~sck_q & sck_q2 & ~ncs_q;
  assign x4        = (state == CMD) ? qpi_mode : quad_q;
  assign sh_in     = x4 ? {sh[19:0], di_q} : {sh[22:0], di_q[0]};
  assign unit_last = x4 ? 8'd1 : 8'd7;
  assign dec       = decode(sh_in[7:0], qpi_mode);
  assign addr_nxt  = addr_inc(addr);
  assign busy      = ~ncs_q && (state != IGNORE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    wait_done = 1'b0;
    byte_done = 1'b0;
    if (rise) begin
      unique case (state)
        CMD:              cmd_done  = (cnt == unit_last);
        ADDR:             addr_done = (cnt == (quad_q ? 8'd5 : 8'd23));
        WAIT:             wait_done = (cnt == wait_q - 8'd1);
        RD_DATA, WR_DATA: byte_done = (cnt == unit_last);
        default: ;
      endcase
    end
    if (ncs_q) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = CMD;
        CMD:  if (cmd_done)
                state_nxt = (!dec.ok || dec.enter || dec.leave) ? IGNORE : ADDR;
        ADDR: if (addr_done)
                state_nxt = (wait_q != 8'd0) ? WAIT : (rd_q ? RD_DATA : WR_DATA);
        WAIT: if (wait_done)
                state_nxt = rd_q ? RD_DATA : WR_DATA;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      sh       <= '0;
      addr     <= '0;
      rd_byte  <= '0;
      rd_q     <= 1'b0;
      quad_q   <= 1'b0;
      wait_q   <= '0;
      qpi_mode <= 1'b0;
      cmd_err  <= 1'b0;
      dout     <= '0;
      do_en    <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (ncs_q) begin
        cnt   <= '0;
        dout  <= '0;
        do_en <= '0;
      end else if (rise) begin
        sh  <= sh_in;
        cnt <= cnt + 8'd1;
        if (cmd_done) begin
          cnt    <= '0;
          rd_q   <= dec.rd;
          quad_q <= dec.quad;
          wait_q <= dec.wait_len;
          if (!dec.ok)   cmd_err  <= 1'b1;
          if (dec.enter) qpi_mode <= 1'b1;
          if (dec.leave) qpi_mode <= 1'b0;
        end
        if (addr_done) begin
          cnt     <= '0;
          addr    <= sh_in[AW-1:0];
          rd_byte <= mem[sh_in[AW-1:0]];
        end
        if (wait_done) begin
          cnt     <= '0;
          rd_byte <= mem[addr];
        end
        if (byte_done) begin
          cnt     <= '0;
          addr    <= addr_nxt;
          rd_byte <= mem[addr_nxt];
        end
      end else if (fall && state == RD_DATA) begin
        // cnt holds the rises already seen in this byte, selecting the next bit/nibble MSB first.
        if (quad_q) begin
          dout  <= cnt[0] ? rd_byte[3:0] : rd_byte[7:4];
          do_en <= 4'b1111;
        end else begin
          dout  <= {2'b00, rd_byte[3'd7 - cnt[2:0]], 1'b0};
          do_en <= 4'b0010;
        end
      end
    end
  end

  // NOTE: the array has no reset on purpose; its contents survive rstn.
  always_ff @(posedge clk) begin
    if (byte_done && state == WR_DATA) mem[addr] <= sh_in[7:0];
  end

endmodule

// File: tb/tb_psram_slave.sv
// Scoreboard bench for psram_slave: stimulus pushes expected read bytes, a monitor on sck rises pops and compares.
`timescale 1ns/1ps
module tb_psram_slave;
`ifdef PSRAM_SLAVE_PAGE_WRAP_EN
  localparam int AW = 11;
`else
  localparam int AW = 10;
`endif

  logic       clk = 1'b0, rstn = 1'b0, ncs = 1'b1, sck = 1'b0;
  logic [3:0] di = 4'h0;
  logic [3:0] dout, do_en;
  logic       qpi_mode, busy, cmd_err;

  psram_slave #(.AW(AW), .FAST_RD_WAIT(8), .QUAD_RD_WAIT(6)) dut (
    .clk(clk), .rstn(rstn), .ncs(ncs), .sck(sck), .di(di),
    .dout(dout), .do_en(do_en), .qpi_mode(qpi_mode), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [3:0] en; } exp_t;
  exp_t sb_q[$];
  int   total = 0, bad = 0;
  int   err_cnt = 0;
  bit   en_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Controller samples on sck rise; a completed byte is compared against the oldest expectation.
  logic [7:0] mon_sh = 8'h00;
  int         mon_n  = 0;
  always @(posedge sck or posedge ncs or negedge rstn) begin
    if (ncs || !rstn) begin
      mon_n = 0;
    end else if (do_en != 4'b0000) begin
      if (do_en == 4'b1111) begin mon_sh = {mon_sh[3:0], dout}; mon_n += 4; end
      else                  begin mon_sh = {mon_sh[6:0], dout[1]}; mon_n += 1; end
      if (mon_n >= 8) begin
        mon_n = 0;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got 0x%0h with nothing expected", mon_sh);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rd_data", 32'(mon_sh), 32'(e.data));
          check("rd_en", 32'(do_en), 32'(e.en));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmd_err) err_cnt++;
    if (do_en != 4'b0000) en_seen = 1'b1;
  end

  task automatic sck_cycle(input logic [3:0] d);
    di = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int nbits, input bit x4);
    if (x4) for (int i = nbits/4 - 1; i >= 0; i--) sck_cycle(v[i*4 +: 4]);
    else    for (int i = nbits - 1; i >= 0; i--)   sck_cycle({3'b000, v[i]});
  endtask

  task automatic cs_low();
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    di  = 4'h0;
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer_cmd(input logic [7:0] cmd, input bit cmd_x4);
    cs_low();
    send(32'(cmd), 8, cmd_x4);
    cs_high();
  endtask

  task automatic xfer_write(input logic [7:0] cmd, input bit cmd_x4, input bit x4,
                            input logic [23:0] a, input logic [63:0] bytes, input int n);
    cs_low();
    check("busy_selected", 32'(busy), 32'd1);
    send(32'(cmd), 8, cmd_x4);
    send(32'(a), 24, x4);
    for (int k = 0; k < n; k++) send(32'(bytes[8*(n-1-k) +: 8]), 8, x4);
    cs_high();
  endtask

  task automatic xfer_read(input logic [7:0] cmd, input bit cmd_x4, input bit x4,
                           input logic [23:0] a, input int nwait,
                           input logic [63:0] bytes, input int n);
    bit wait_en_bad;
    wait_en_bad = 1'b0;
    cs_low();
    send(32'(cmd), 8, cmd_x4);
    send(32'(a), 24, x4);
    for (int w = 0; w < nwait; w++) begin
      sck_cycle(4'h0);
      if (do_en != 4'b0000) wait_en_bad = 1'b1;
    end
    if (nwait > 0) check("wait_do_en_zero", 32'(wait_en_bad), 32'd0);
    for (int k = 0; k < n; k++)
      sb_q.push_back('{data: bytes[8*(n-1-k) +: 8], en: (x4 ? 4'b1111 : 4'b0010)});
    for (int c = 0; c < n * (x4 ? 2 : 8); c++) sck_cycle(4'h0);
    cs_high();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_do_en", 32'(do_en), 32'd0);
    check("rst_qpi", 32'(qpi_mode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Single-width write then read
    xfer_write(8'h02, 1'b0, 1'b0, 24'h000010, 64'hA53C, 2);
    xfer_read (8'h03, 1'b0, 1'b0, 24'h000010, 0, 64'hA53C, 2);

    // Quad write then quad read with 6 dummy cycles
    xfer_write(8'h38, 1'b0, 1'b1, 24'h000100, 64'h0001020304050607, 8);
    xfer_read (8'hEB, 1'b0, 1'b1, 24'h000100, 6, 64'h0001020304050607, 8);

    // QPI entry, nibble-wide read, exit
    xfer_cmd(8'h35, 1'b0);
    check("qpi_entered", 32'(qpi_mode), 32'd1);
    xfer_read(8'h03, 1'b1, 1'b1, 24'h000100, 6, 64'h0001, 2);
    xfer_cmd(8'hF5, 1'b1);
    check("qpi_exited", 32'(qpi_mode), 32'd0);

    // Unsupported command: one cmd_err pulse, outputs stay off, IGNORE drops busy
    cs_low();
    err_cnt = 0;
    en_seen = 1'b0;
    send(32'h9F, 8, 1'b0);
    for (int i = 0; i < 8; i++) sck_cycle(4'h1);
    check("ignore_busy", 32'(busy), 32'd0);
    cs_high();
    check("cmd_err_pulses", 32'(err_cnt), 32'd1);
    check("ignore_do_en", 32'(en_seen), 32'd0);

    // Abort mid-byte: completed byte committed, partial byte discarded
    xfer_write(8'h02, 1'b0, 1'b0, 24'h000021, 64'h77, 1);
    cs_low();
    send(32'h02, 8, 1'b0);
    send(32'h000020, 24, 1'b0);
    send(32'h11, 8, 1'b0);
    send(32'hF, 4, 1'b0);
    cs_high();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_do_en", 32'(do_en), 32'd0);
    xfer_read(8'h03, 1'b0, 1'b0, 24'h000020, 0, 64'h1177, 2);

    // Address wrap from 0x3FF
    xfer_write(8'h02, 1'b0, 1'b0, 24'h0003FF, 64'hC1C2C3, 3);
    xfer_read (8'h03, 1'b0, 1'b0, 24'h0003FF, 0, 64'hC1C2C3, 3);
    xfer_read (8'h03, 1'b0, 1'b0, 24'h000000, 0, 64'hC2C3, 2);

    // Reset mid-read
    cs_low();
    send(32'h03, 8, 1'b0);
    send(32'h000010, 24, 1'b0);
    for (int i = 0; i < 4; i++) sck_cycle(4'h0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_do_en", 32'(do_en), 32'd0);
    check("mid_rst_qpi", 32'(qpi_mode), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
    ncs = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    xfer_read(8'h03, 1'b0, 1'b0, 24'h000010, 0, 64'hA53C, 2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
